cs_window_gen: RTL and testbench

Parametrised sliding-window approximate-average filter, the next generation of the fixed 8-bit/9-tap CS block. It accepts one DW-bit sample per qualified cycle and keeps the last N samples in a circular buffer with a running sum. It computes an approximate average Xappr and emits Y = (sum + N·Xappr) >> SH. New in this generation: configurable width and depth, an input-valid/output-valid handshake, a selectable approximation direction and a synchronous window clear. It sits in the sample datapath between the input register stage and the downstream result checker.

---
 rtl/cs_window_gen.sv | 60 ++++++
 tb/tb_cs_window_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/cs_window_gen.sv
// cs_window_gen: sliding-window approximate-average filter, Y = (S + N*Xappr) >> SH over the last N samples
module cs_window_gen #(
  parameter int DW = 8,
  parameter int N  = 9,
  parameter int SH = 3,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic          mode,
  input  logic          clear,
  output logic [OW-1:0] Y,
  output logic          out_valid
);
  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(N);
  localparam int SW = DW + $clog2(N);
  localparam logic [SW-1:0] NW = SW'(N);
  localparam logic [CW-1:0] CN = CW'(N);
  logic [DW-1:0] buff [N];
  logic [WW-1:0] wp;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s;
  logic          v1;
  logic [DW-1:0] xa;
  logic [SW:0]   yf;
  // N*Xi compared against S stands in for Xi compared against S/N
  always_comb begin
    xa = mode ? '1 : '0;
    for (int i = 0; i < N; i++)
      if (mode ? (NW * SW'(buff[i]) >= s && buff[i] < xa) : (NW * SW'(buff[i]) <= s && buff[i] > xa))
        xa = buff[i];
    yf = {1'b0, s} + {1'b0, NW * SW'(xa)};
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt       <= '0;
      s         <= '0;
      wp        <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      if (reset) Y <= '0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1 && cnt == CN;
      Y         <= (v1 && cnt == CN) ? OW'(yf >> SH) : Y;
      if (in_valid) begin
        buff[wp] <= X;
        wp       <= (wp == WW'(N - 1)) ? '0 : wp + 1'b1;
        if (cnt == CN) s <= s + SW'(X) - SW'(buff[wp]);
        else begin
          s   <= s + SW'(X);
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cs_window_gen.sv
// tb_cs_window_gen: table-driven directed vectors plus hand-written reset/refill sequence
module tb_cs_window_gen;
  logic       clk = 0;
  logic       reset, in_valid, mode, clear;
  logic [7:0] X;
  logic [9:0] Y;
  logic       out_valid;
  int total = 0, bad = 0;

  typedef struct {
    logic       rs, iv, cl, md;
    logic [7:0] x;
    logic       ov;
    logic [9:0] y;
  } vec_t;
  vec_t q[$];

  cs_window_gen dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .mode(mode),
    .clear(clear), .Y(Y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic void add(input logic rs, iv, cl, md, input logic [7:0] x, input logic ov, input logic [9:0] y);
    q.push_back('{rs, iv, cl, md, x, ov, y});
  endfunction

  task automatic drive(input logic rs, iv, cl, md, input logic [7:0] x);
    reset = rs; in_valid = iv; clear = cl; mode = md; X = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    reset = 1; in_valid = 0; clear = 0; mode = 0; X = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset Y", Y, 0);
    chk("reset ov", out_valid, 0);
    // 1..9 in both modes
    for (int i = 1; i <= 9; i++) add(0, 1, 0, 0, 8'(i), 0, 0);
    add(0, 0, 0, 0, 0, 1, 11);
    add(0, 0, 1, 1, 0, 0, 11);
    for (int i = 1; i <= 9; i++) add(0, 1, 0, 1, 8'(i), 0, 11);
    add(0, 0, 0, 1, 0, 1, 11);
    // eight zeros then 255
    add(0, 0, 1, 0, 0, 0, 11);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, 0, 11);
    add(0, 1, 0, 0, 255, 0, 11);
    add(0, 0, 0, 0, 0, 1, 31);
    add(0, 0, 1, 1, 0, 0, 31);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 0, 0, 31);
    add(0, 1, 0, 1, 255, 0, 31);
    add(0, 0, 0, 1, 0, 1, 318);
    // full-scale window, back-to-back results, mode switched at stage 2
    add(0, 0, 1, 0, 0, 0, 318);
    for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 255, 0, 318);
    add(0, 1, 0, 0, 0, 1, 573);
    add(0, 0, 0, 0, 0, 1, 255);
    add(0, 1, 0, 0, 0, 0, 255);
    add(0, 0, 0, 1, 0, 1, 510);
    // gap of three idle cycles, then sample 10 -> window 2..10
    add(0, 0, 1, 0, 0, 0, 510);
    for (int i = 1; i <= 9; i++) add(0, 1, 0, 0, 8'(i), 0, 510);
    add(0, 0, 0, 0, 0, 1, 11);
    add(0, 0, 0, 0, 0, 0, 11);
    add(0, 0, 0, 0, 0, 0, 11);
    add(0, 1, 0, 0, 10, 0, 11);
    add(0, 0, 0, 0, 0, 1, 13);
    // clear together with sample 5 drops it; window becomes 6..14
    add(0, 0, 1, 0, 0, 0, 13);
    for (int i = 1; i <= 4; i++) add(0, 1, 0, 0, 8'(i), 0, 13);
    add(0, 1, 1, 0, 5, 0, 13);
    for (int i = 6; i <= 14; i++) add(0, 1, 0, 0, 8'(i), 0, 13);
    add(0, 0, 0, 0, 0, 1, 22);
    foreach (q[i]) begin
      drive(q[i].rs, q[i].iv, q[i].cl, q[i].md, q[i].x);
      chk($sformatf("vec%0d ov", i), out_valid, q[i].ov);
      chk($sformatf("vec%0d Y", i), Y, q[i].y);
    end
    // reset mid-stream, then refill exactly as from power-up
    for (int i = 1; i <= 5; i++) drive(0, 1, 0, 0, 8'(i));
    drive(1, 1, 0, 0, 77);
    chk("midreset Y", Y, 0);
    chk("midreset ov", out_valid, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(0, 1, 0, 0, 8'(i));
      chk($sformatf("refill%0d ov", i), out_valid, 0);
    end
    cyc = 0;
    do begin
      drive(0, 0, 0, 0, 0);
      cyc++;
    end while (!out_valid && cyc < 5);
    chk("refill latency", cyc, 1);
    chk("refill Y", Y, 11);
    drive(0, 0, 0, 0, 0);
    chk("refill single pulse", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
